sprite_draw_sequencer: RTL and testbench

- Upstream command generator for the MIF draw stage.
- Once per animation frame it issues two draw commands over the draw/ready handshake:
  - an erase: a blank MIF drawn at the sprite's previous position;
  - a draw: the next walk-cycle MIF at the updated position.
- Position updates come from the left/right user inputs; the horizontal limits use the image width reported by the draw stage.

---
 rtl/sprite_draw_sequencer.sv | 179 +++++++++++++++++
 tb/tb_sprite_draw_sequencer.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_draw_sequencer.sv
// Sprite animation command generator: once per frame it issues an erase at the
// last drawn position, then the next walk-cycle image at the updated position.
module sprite_draw_sequencer #(
  parameter int         CLOCK_FREQ   = 50000000,
  parameter int         FRAME_RATE   = 10,
  parameter int         LCD_WIDTH    = 240,
  parameter int         FRAME_COUNT  = 3,
  parameter logic [7:0] BASE_MIF_ID  = 8'd0,
  parameter logic [7:0] BLANK_MIF_ID = 8'd255,
  parameter int         STEP         = 2,
  parameter int         X_START      = 0,
  parameter int         Y_POS        = 200
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       moveLeft,
  input  logic       moveRight,
  input  logic       drawReady,
  input  logic [7:0] imgWidth,
  output logic [7:0] xOrigin,
  output logic [8:0] yOrigin,
  output logic [7:0] mifId,
  output logic       draw,
  output logic       busy,
  output logic       overrun
);

  localparam int TICK_DIV = CLOCK_FREQ / FRAME_RATE;
  localparam int CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int FIDX_W   = (FRAME_COUNT > 1) ? $clog2(FRAME_COUNT) : 1;

  localparam logic [CNT_W-1:0]  TICK_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [FIDX_W-1:0] FIDX_LAST = FIDX_W'(FRAME_COUNT - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_ERASE_REQ = 3'd1;
  localparam logic [2:0] S_ERASE_ACK = 3'd2;
  localparam logic [2:0] S_UPDATE    = 3'd3;
  localparam logic [2:0] S_DRAW_REQ  = 3'd4;
  localparam logic [2:0] S_DRAW_ACK  = 3'd5;

  logic [2:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              pend_q, pend_d;
  logic              overrun_q, overrun_d;
  logic [7:0]        xpos_q, xpos_d;
  logic [FIDX_W-1:0] fidx_q, fidx_d;
  logic              first_q, first_d;
  logic [7:0]        xo_q, xo_d;
  logic [7:0]        mif_q, mif_d;
  logic              draw_q, draw_d;
  logic              tick;

  // Horizontal step with clamping done in 9 bits so a right step near 255 cannot wrap.
  function automatic logic [7:0] next_x(input logic [7:0] x, input logic left,
                                        input logic right, input logic [7:0] width);
    logic [8:0] max_x;
    logic [8:0] sum;
    logic [8:0] res;
    max_x = ({1'b0, width} > 9'(LCD_WIDTH)) ? 9'd0 : 9'(LCD_WIDTH) - {1'b0, width};
    sum   = {1'b0, x} + 9'(STEP);
    res   = {1'b0, x};
    if (right && !left) begin
      res = (sum > max_x) ? max_x : sum;
    end else if (left && !right) begin
      res = ({1'b0, x} < 9'(STEP)) ? 9'd0 : {1'b0, x} - 9'(STEP);
    end
    return 8'(res);
  endfunction

  always_comb begin
    tick      = (cnt_q == TICK_LAST);
    cnt_d     = tick ? '0 : cnt_q + 1'b1;
    state_d   = state_q;
    pend_d    = pend_q;
    overrun_d = overrun_q;
    xpos_d    = xpos_q;
    fidx_d    = fidx_q;
    first_d   = first_q;
    xo_d      = xo_q;
    mif_d     = mif_q;
    draw_d    = draw_q;

    // A tick landing while a frame is in flight is remembered once; a second one is lost.
    if (state_q != S_IDLE) begin
      if (tick) begin
        if (pend_q) overrun_d = 1'b1;
        else        pend_d    = 1'b1;
      end
    end else begin
      pend_d = pend_q && tick;
    end

    case (state_q)
      S_IDLE: begin
        if (tick || pend_q) begin
          if (first_q) begin
            state_d = S_UPDATE;
          end else begin
            state_d = S_ERASE_REQ;
            xo_d    = xpos_q;
            mif_d   = BLANK_MIF_ID;
          end
        end
      end
      S_ERASE_REQ: begin
        if (drawReady) begin
          draw_d  = 1'b1;
          state_d = S_ERASE_ACK;
        end
      end
      S_ERASE_ACK: begin
        if (!drawReady) begin
          draw_d  = 1'b0;
          state_d = S_UPDATE;
        end
      end
      S_UPDATE: begin
        xpos_d = next_x(xpos_q, moveLeft, moveRight, imgWidth);
        if (moveLeft != moveRight) fidx_d = (fidx_q == FIDX_LAST) ? '0 : fidx_q + 1'b1;
        else                       fidx_d = '0;
        first_d = 1'b0;
        xo_d    = xpos_d;
        mif_d   = BASE_MIF_ID + 8'(fidx_d);
        state_d = S_DRAW_REQ;
      end
      S_DRAW_REQ: begin
        if (drawReady) begin
          draw_d  = 1'b1;
          state_d = S_DRAW_ACK;
        end
      end
      S_DRAW_ACK: begin
        if (!drawReady) begin
          draw_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        draw_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      pend_q    <= 1'b0;
      overrun_q <= 1'b0;
      xpos_q    <= 8'(X_START);
      fidx_q    <= '0;
      first_q   <= 1'b1;
      xo_q      <= 8'(X_START);
      mif_q     <= BASE_MIF_ID;
      draw_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      overrun_q <= overrun_d;
      xpos_q    <= xpos_d;
      fidx_q    <= fidx_d;
      first_q   <= first_d;
      xo_q      <= xo_d;
      mif_q     <= mif_d;
      draw_q    <= draw_d;
    end
  end

  assign xOrigin = xo_q;
  assign yOrigin = 9'(Y_POS);
  assign mifId   = mif_q;
  assign draw    = draw_q;
  assign busy    = (state_q != S_IDLE);
  assign overrun = overrun_q;

endmodule

// File: tb/tb_sprite_draw_sequencer.sv
// Scoreboard bench: each task pushes the commands it expects; a monitor pops and
// compares them on every rising edge of draw.
module tb_sprite_draw_sequencer;

  localparam int TD = 100;  // CLOCK_FREQ/FRAME_RATE below

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       moveLeft = 1'b0;
  logic       moveRight = 1'b0;
  logic       drawReady = 1'b1;
  logic [7:0] imgWidth = 8'd40;
  logic [7:0] xOrigin;
  logic [8:0] yOrigin;
  logic [7:0] mifId;
  logic       draw;
  logic       busy;
  logic       overrun;

  typedef struct {
    logic [7:0] x;
    logic [7:0] mif;
  } cmd_t;

  cmd_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   x_m = 0;
  int   fidx_m = 0;
  bit   first_m = 1'b1;
  bit   hold_low = 1'b0;

  sprite_draw_sequencer #(
    .CLOCK_FREQ(1000), .FRAME_RATE(10), .LCD_WIDTH(240), .FRAME_COUNT(3),
    .BASE_MIF_ID(8'd0), .BLANK_MIF_ID(8'd255), .STEP(2), .X_START(0), .Y_POS(200)
  ) dut (
    .clock(clock), .reset(reset), .moveLeft(moveLeft), .moveRight(moveRight),
    .drawReady(drawReady), .imgWidth(imgWidth), .xOrigin(xOrigin), .yOrigin(yOrigin),
    .mifId(mifId), .draw(draw), .busy(busy), .overrun(overrun)
  );

  always #5 clock = ~clock;

  // Draw-stage model: ready drops 2 cycles after draw rises, returns 3 cycles after draw falls.
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(negedge clock);
      if (hold_low) begin
        drawReady = 1'b0;
        cnt = 0;
      end else if (draw && drawReady) begin
        cnt++;
        if (cnt >= 2) begin drawReady = 1'b0; cnt = 0; end
      end else if (!draw && !drawReady) begin
        cnt++;
        if (cnt >= 3) begin drawReady = 1'b1; cnt = 0; end
      end else begin
        cnt = 0;
      end
    end
  end

  initial begin
    logic       dprev;
    logic [7:0] hx, hm;
    cmd_t       e;
    dprev = 1'b0;
    hx = '0;
    hm = '0;
    forever begin
      @(negedge clock);
      if (draw === 1'b1 && !dprev) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL cmd_unexpected got x=%0d mif=%0d required no command", xOrigin, mifId);
        end else begin
          e = exp_q.pop_front();
          if (xOrigin !== e.x || mifId !== e.mif || yOrigin !== 9'd200) begin
            errors++;
            $display("FAIL cmd got x=%0d y=%0d mif=%0d required x=%0d y=200 mif=%0d",
                     xOrigin, yOrigin, mifId, e.x, e.mif);
          end
        end
        hx = xOrigin;
        hm = mifId;
      end else if (draw === 1'b1 && dprev) begin
        checks++;
        if (xOrigin !== hx || mifId !== hm || yOrigin !== 9'd200) begin
          errors++;
          $display("FAIL hold got x=%0d mif=%0d required x=%0d mif=%0d", xOrigin, mifId, hx, hm);
        end
      end
      dprev = (draw === 1'b1);
    end
  end

  task automatic push_frame(input bit l, input bit r, input int w);
    cmd_t c;
    int   mx;
    if (!first_m) begin
      c.x = 8'(x_m);
      c.mif = 8'd255;
      exp_q.push_back(c);
    end
    mx = (w > 240) ? 0 : 240 - w;
    if (r && !l)      x_m = (x_m + 2 > mx) ? mx : x_m + 2;
    else if (l && !r) x_m = (x_m < 2) ? 0 : x_m - 2;
    fidx_m = (l != r) ? (fidx_m + 1) % 3 : 0;
    first_m = 1'b0;
    c.x = 8'(x_m);
    c.mif = 8'(fidx_m);
    exp_q.push_back(c);
  endtask

  task automatic wait_frame();
    int n;
    n = 0;
    while (busy !== 1'b1 && n < 400) begin @(negedge clock); n++; end
    checks++;
    if (n >= 400) begin errors++; $display("FAIL frame_start got busy=%0b required 1", busy); end
    n = 0;
    while (busy !== 1'b0 && n < 400) begin @(negedge clock); n++; end
    checks++;
    if (n >= 400) begin errors++; $display("FAIL frame_end got busy=%0b required 0", busy); end
  endtask

  task automatic run_frames(input int nf, input bit l, input bit r, input int w);
    for (int i = 0; i < nf; i++) begin
      moveLeft = l;
      moveRight = r;
      imgWidth = 8'(w);
      push_frame(l, r, w);
      wait_frame();
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #1;
    checks++;
    if (draw !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0 || xOrigin !== 8'd0 ||
        yOrigin !== 9'd200 || mifId !== 8'd0) begin
      errors++;
      $display("FAIL reset got draw=%0b busy=%0b ovr=%0b x=%0d y=%0d mif=%0d required 0 0 0 0 200 0",
               draw, busy, overrun, xOrigin, yOrigin, mifId);
    end
    repeat (3) @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_first_frame();
    int n;
    n = 0;
    push_frame(1'b0, 1'b0, 40);
    while (draw !== 1'b1 && n < 300) begin @(negedge clock); n++; end
    checks++;
    if (n < TD + 1 || n > TD + 2) begin
      errors++;
      $display("FAIL first_draw_latency got %0d cycles required %0d..%0d", n, TD + 1, TD + 2);
    end
    wait_frame();
  endtask

  task automatic test_walk_right();
    run_frames(4, 1'b0, 1'b1, 40);
    checks++;
    if (xOrigin !== 8'd8 || mifId !== 8'd1) begin
      errors++;
      $display("FAIL walk_right got x=%0d mif=%0d required x=8 mif=1", xOrigin, mifId);
    end
  endtask

  task automatic test_right_clamp();
    int guard;
    guard = 0;
    while (x_m != 199 && guard < 200) begin
      run_frames(1, 1'b0, 1'b1, 41);
      guard++;
    end
    checks++;
    if (xOrigin !== 8'd199) begin
      errors++;
      $display("FAIL clamp_199 got x=%0d required 199", xOrigin);
    end
    run_frames(1, 1'b0, 1'b1, 40);
    checks++;
    if (xOrigin !== 8'd200) begin
      errors++;
      $display("FAIL clamp_200 got x=%0d required 200", xOrigin);
    end
    run_frames(2, 1'b0, 1'b1, 40);
    checks++;
    if (xOrigin !== 8'd200) begin
      errors++;
      $display("FAIL clamp_hold got x=%0d required 200", xOrigin);
    end
  endtask

  task automatic test_left_clamp();
    run_frames(1, 1'b0, 1'b1, 239);
    checks++;
    if (xOrigin !== 8'd1) begin errors++; $display("FAIL to_x1 got x=%0d required 1", xOrigin); end
    run_frames(1, 1'b1, 1'b0, 239);
    checks++;
    if (xOrigin !== 8'd0) begin errors++; $display("FAIL left_clamp got x=%0d required 0", xOrigin); end
    run_frames(1, 1'b1, 1'b1, 239);
    checks++;
    if (xOrigin !== 8'd0 || mifId !== 8'd0) begin
      errors++;
      $display("FAIL standing got x=%0d mif=%0d required x=0 mif=0", xOrigin, mifId);
    end
  endtask

  task automatic test_overrun();
    int  n;
    bit  saw_draw;
    saw_draw = 1'b0;
    moveLeft = 1'b0;
    moveRight = 1'b0;
    imgWidth = 8'd40;
    hold_low = 1'b1;
    n = 0;
    while (busy !== 1'b1 && n < 300) begin @(negedge clock); n++; end
    checks++;
    if (n >= 300) begin errors++; $display("FAIL ovr_start got busy=%0b required 1", busy); end
    for (int i = 0; i < 150; i++) begin @(negedge clock); if (draw !== 1'b0) saw_draw = 1'b1; end
    checks++;
    if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_early got %0b required 0", overrun); end
    for (int i = 0; i < 100; i++) begin @(negedge clock); if (draw !== 1'b0) saw_draw = 1'b1; end
    checks++;
    if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set got %0b required 1", overrun); end
    checks++;
    if (saw_draw) begin errors++; $display("FAIL ovr_draw got draw=1 required 0 while stalled"); end
    // The stalled frame finishes, then the remembered tick runs one more frame.
    push_frame(1'b0, 1'b0, 40);
    push_frame(1'b0, 1'b0, 40);
    hold_low = 1'b0;
    wait_frame();
    wait_frame();
    repeat (5) @(negedge clock);
    checks++;
    if (busy !== 1'b0 || overrun !== 1'b1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL ovr_after got busy=%0b ovr=%0b pending=%0d required busy=0 ovr=1 pending=0",
               busy, overrun, exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int n;
    moveLeft = 1'b0;
    moveRight = 1'b1;
    imgWidth = 8'd40;
    push_frame(1'b0, 1'b1, 40);
    n = 0;
    while (!(draw === 1'b1 && mifId !== 8'd255) && n < 400) begin @(negedge clock); n++; end
    checks++;
    if (n >= 400) begin errors++; $display("FAIL mid_wait got draw=%0b required draw command", draw); end
    @(negedge clock);
    #1 reset = 1'b0;
    #1;
    checks++;
    if (draw !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset got draw=%0b busy=%0b ovr=%0b required 0 0 0", draw, busy, overrun);
    end
    x_m = 0;
    fidx_m = 0;
    first_m = 1'b1;
    moveRight = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    push_frame(1'b0, 1'b0, 40);
    wait_frame();
    checks++;
    if (exp_q.size() != 0 || xOrigin !== 8'd0 || mifId !== 8'd0) begin
      errors++;
      $display("FAIL post_reset got pending=%0d x=%0d mif=%0d required 0 0 0",
               exp_q.size(), xOrigin, mifId);
    end
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_walk_right();
    test_right_clamp();
    test_left_clamp();
    test_overrun();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
